// File: rtl/uart_imem_loader_if.sv
// Loader bus: UART receive strobe in, instruction memory write port and
// boot status out. The master modport is the loader side.
interface uart_imem_loader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_err;

    modport master (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_data, cpu_hold, load_done, load_err
    );

    modport slave (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_data, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/uart_imem_loader.sv
// UART boot loader: frame = SYNC_BYTE, word count N, N little-endian words.
// Each completed word is written to instruction memory one cycle after its
// last byte. cpu_hold is released only after a complete, valid image.
// Optional macro UART_IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match before the image is accepted.
module uart_imem_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input logic clk,
    input logic rst,
    uart_imem_loader_if.master bus
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t                state, state_nx;
    logic [7:0]            len_q;
    logic [7:0]            word_cnt;
    logic [BCW-1:0]        byte_cnt;
    logic [DATA_WIDTH-1:0] word_buf;
    logic [TCW-1:0]        tmo_cnt;
    logic                  we_q, hold_q, done_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            xor_q;
    logic                  last_word;
`endif

    logic                  sync_hit, len_bad, len_accept, byte_take;
    logic                  last_byte, tmo_hit;
    logic [DATA_WIDTH-1:0] asm_word;

    assign sync_hit  = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    assign len_bad   = (bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > 9'(DEPTH));
    assign last_byte = (byte_cnt == BCW'(BYTES - 1));
    assign tmo_hit   = (tmo_cnt == TCW'(TIMEOUT - 1));
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    assign last_word = (8'(word_cnt + 8'd1) == len_q);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and per-cycle datapath strobes
    always_comb begin
        state_nx   = state;
        len_accept = 1'b0;
        byte_take  = 1'b0;
        asm_word   = word_buf;
        asm_word[byte_cnt*8 +: 8] = bus.rx_data;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (sync_hit) state_nx = S_LEN;
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    if (len_bad) begin
                        state_nx = S_ERR;
                    end else begin
                        len_accept = 1'b1;
                        state_nx   = S_DATA;
                    end
                end else if (tmo_hit) begin
                    state_nx = S_ERR;
                end
            end
            S_DATA: begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                if (bus.rx_valid) begin
                    byte_take = 1'b1;
                    // Move to CHK on the last byte so a checksum byte arriving
                    // during the final write pulse is still caught.
                    if (last_byte && last_word) state_nx = S_CHK;
                end else if (tmo_hit) begin
                    state_nx = S_ERR;
                end
`else
                // word_cnt reaches len_q only during the final write pulse.
                if (word_cnt == len_q) begin
                    state_nx = S_DONE;
                end else if (bus.rx_valid) begin
                    byte_take = 1'b1;
                end else if (tmo_hit) begin
                    state_nx = S_ERR;
                end
`endif
            end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (bus.rx_valid) begin
                    state_nx = (bus.rx_data == xor_q) ? S_DONE : S_ERR;
                end else if (tmo_hit) begin
                    state_nx = S_ERR;
                end
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // Byte assembly, write port, status flags and inter-byte timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            tmo_cnt  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (state_nx == S_LEN && state != S_LEN) begin
                hold_q <= 1'b1;
                done_q <= 1'b0;
                err_q  <= 1'b0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                xor_q  <= '0;
`endif
            end
            if (len_accept) begin
                len_q    <= bus.rx_data;
                word_cnt <= '0;
                byte_cnt <= '0;
                addr_q   <= '0;
            end
            if (byte_take) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                xor_q <= xor_q ^ bus.rx_data;
`endif
                if (last_byte) begin
                    we_q     <= 1'b1;
                    data_q   <= asm_word;
                    addr_q   <= ADDR_WIDTH'(word_cnt);
                    word_cnt <= 8'(word_cnt + 8'd1);
                    byte_cnt <= '0;
                end else begin
                    word_buf <= asm_word;
                    byte_cnt <= BCW'(byte_cnt + 1'b1);
                end
            end
            if (state_nx == S_ERR && state != S_ERR) begin
                err_q  <= 1'b1;
                hold_q <= 1'b1;
                done_q <= 1'b0;
            end
            if (state_nx == S_DONE && state != S_DONE) begin
                hold_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (bus.rx_valid || state_nx != state) begin
                tmo_cnt <= '0;
            end else if (state == S_LEN || state == S_DATA
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                         || state == S_CHK
`endif
                        ) begin
                tmo_cnt <= TCW'(tmo_cnt + 1'b1);
            end
        end
    end

    assign bus.imem_we   = we_q;
    assign bus.imem_addr = addr_q;
    assign bus.imem_data = data_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.load_done = done_q;
    assign bus.load_err  = err_q;

endmodule
